// File: rtl/uart_core_if.sv
// Bus bundle between the CPU bus mux and uart_core.
// cs/we/address/write_data in; registered read_data and ready out.
interface uart_core_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output cs, we, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  cs, we, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/uart_core.sv
// Memory-mapped 8N1 UART: RX deserialiser with byte FIFO, TX serialiser.
// Ports: clk, rst_n, bus (uart_core_if.slave), rxd in, txd out.
// Optional: UART_LOOPBACK_EN adds LOOPBACK register at 0x50.
module uart_core #(
  parameter logic [15:0] DEFAULT_BIT_RATE = 16'd217,
  parameter int          FIFO_ADDR_BITS   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_core_if.slave bus,
  input  logic       rxd,
  output logic       txd
);

  localparam logic [7:0] A_RATE  = 8'h10;
  localparam logic [7:0] A_RXST  = 8'h20;
  localparam logic [7:0] A_RXDAT = 8'h21;
  localparam logic [7:0] A_RXCNT = 8'h22;
  localparam logic [7:0] A_TXST  = 8'h40;
  localparam logic [7:0] A_TXDAT = 8'h41;
  localparam logic [7:0] A_LOOP  = 8'h50;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int AW    = FIFO_ADDR_BITS;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT =
    {1'b1, {AW{1'b0}}};

  // ---------------- bus decode ----------------
  logic acc_rd;
  logic acc_wr;
  assign acc_rd = bus.cs & ~bus.we;
  assign acc_wr = bus.cs &  bus.we;

  logic hit_rate, hit_rxst, hit_rxdat;
  logic hit_rxcnt, hit_txst, hit_txdat;
  logic hit_loop;
  assign hit_rate  = bus.address == A_RATE;
  assign hit_rxst  = bus.address == A_RXST;
  assign hit_rxdat = bus.address == A_RXDAT;
  assign hit_rxcnt = bus.address == A_RXCNT;
  assign hit_txst  = bus.address == A_TXST;
  assign hit_txdat = bus.address == A_TXDAT;
`ifdef UART_LOOPBACK_EN
  assign hit_loop  = bus.address == A_LOOP;
`else
  assign hit_loop  = 1'b0;
`endif

  logic rd_status;
  logic rd_pop;
  logic wr_rate;
  logic wr_tx;
  assign rd_status = acc_rd & hit_rxst;
  assign rd_pop    = acc_rd & hit_rxdat;
  assign wr_rate   = acc_wr & hit_rate;
  assign wr_tx     = acc_wr & hit_txdat;

  logic unused_ok;
  assign unused_ok = ^bus.write_data[31:16];

  // ---------------- registers ----------------
  logic [15:0] rate_q, rate_d;
  logic        ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        loop_q;

  always_comb begin
    rate_d = rate_q;
    if (wr_rate) begin
      if (bus.write_data[15:0] < 16'd2)
        rate_d = 16'd2;
      else
        rate_d = bus.write_data[15:0];
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]    fifo_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic          rx_done, rx_ferr;
  logic [7:0]    rx_sh_q, rx_sh_d;

  assign fifo_full  = cnt_q == FULL_CNT;
  assign fifo_empty = cnt_q == '0;
  assign push       = rx_done & ~fifo_full;
  assign pop        = rd_pop & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= rx_sh_q;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------- TX ----------------
  logic [1:0]  tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_per_q, tx_per_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_ready;
  logic        tx_end;
  logic        tx_line;

  assign tx_ready = tx_st_q == S_IDLE;
  assign tx_end   = tx_cnt_q == tx_per_q - 16'd1;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + 16'd1;
    tx_per_d = tx_per_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (wr_tx) begin
          tx_st_d  = S_START;
          tx_per_d = rate_q;
          tx_sh_d  = bus.write_data[7:0];
        end
      end
      S_START: if (tx_end) begin
        tx_st_d  = S_DATA;
        tx_cnt_d = '0;
        tx_per_d = rate_q;
        tx_bit_d = '0;
      end
      S_DATA: if (tx_end) begin
        tx_cnt_d = '0;
        tx_per_d = rate_q;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        if (tx_bit_q == 3'd7)
          tx_st_d = S_STOP;
        else
          tx_bit_d = tx_bit_q + 3'd1;
      end
      S_STOP: if (tx_end) begin
        tx_st_d  = S_IDLE;
        tx_cnt_d = '0;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (tx_st_q)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_sh_q[0];
      default: tx_line = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  logic        rx_src;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_fall;
  logic [1:0]  rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] rx_per_q, rx_per_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_end;
  logic [15:0] rx_half_m1;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loop_q ? tx_line : rxd;
  assign txd    = loop_q ? 1'b1 : tx_line;
`else
  assign rx_src = rxd;
  assign txd    = tx_line;
`endif

  assign rx_fall    = rx_prev_q & ~rx_sync_q;
  assign rx_end     = rx_cnt_q == rx_per_q - 16'd1;
  // rate is always >= 2, so half-period is >= 1
  assign rx_half_m1 =
    {1'b0, rx_per_q[15:1]} - 16'd1;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_per_d = rx_per_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_done  = 1'b0;
    rx_ferr  = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_st_d  = S_START;
          rx_per_d = rate_q;
        end
      end
      S_START: if (rx_cnt_q == rx_half_m1) begin
        rx_cnt_d = '0;
        rx_per_d = rate_q;
        rx_bit_d = '0;
        rx_st_d  = rx_sync_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_end) begin
        rx_cnt_d = '0;
        rx_per_d = rate_q;
        rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7)
          rx_st_d = S_STOP;
        else
          rx_bit_d = rx_bit_q + 3'd1;
      end
      S_STOP: if (rx_end) begin
        rx_st_d  = S_IDLE;
        rx_cnt_d = '0;
        rx_done  = rx_sync_q;
        rx_ferr  = ~rx_sync_q;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  // set beats a same-cycle status-read clear
  assign ferr_d = rx_ferr | (ferr_q & ~rd_status);
  assign ovr_d  = (rx_done & fifo_full) |
                  (ovr_q & ~rd_status);

  // ---------------- read mux ----------------
  always_comb begin
    rdata_d = '0;
    if (acc_rd) begin
      unique case (1'b1)
        hit_rate:  rdata_d = {16'b0, rate_q};
        hit_rxst:  rdata_d = {29'b0, ferr_q,
                              ovr_q, ~fifo_empty};
        hit_rxdat: if (!fifo_empty)
                     rdata_d = {24'b0, fifo_q[rptr_q]};
        hit_rxcnt: rdata_d =
                     {{(31 - AW){1'b0}}, cnt_q};
        hit_txst:  rdata_d = {31'b0, tx_ready};
        hit_loop:  rdata_d = {31'b0, loop_q};
        default:   rdata_d = '0;
      endcase
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q    <= DEFAULT_BIT_RATE;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_per_q  <= DEFAULT_BIT_RATE;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_per_q  <= DEFAULT_BIT_RATE;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rate_q    <= rate_d;
      ready_q   <= bus.cs;
      rdata_q   <= rdata_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_per_q  <= tx_per_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_meta_q <= rx_src;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_per_q  <= rx_per_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      loop_q <= 1'b0;
    else if (acc_wr && hit_loop)
      loop_q <= bus.write_data[0];
  end
`else
  assign loop_q = 1'b0;
`endif

  assign bus.ready     = ready_q;
  assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core.
// Covers bus, RX/FIFO/flags, TX framing, reset and optional loopback.
module tb_uart_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic txd;
  int   checks = 0;
  int   failures = 0;

  uart_core_if bus ();

  uart_core #(
    .DEFAULT_BIT_RATE(16'd217),
    .FIFO_ADDR_BITS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .rxd(rxd),
    .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1;
    bus.we = 1'b1;
    bus.address = a;
    bus.write_data = d;
    @(negedge clk);
    bus.cs = 1'b0;
    bus.we = 1'b0;
    check("wr_ready", {31'b0, bus.ready}, 32'd1);
  endtask

  task automatic bus_rd(input logic [7:0] a,
                        output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1;
    bus.we = 1'b0;
    bus.address = a;
    @(negedge clk);
    bus.cs = 1'b0;
    check("rd_ready", {31'b0, bus.ready}, 32'd1);
    d = bus.read_data;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [7:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input int rate);
    @(negedge clk);
    rxd = 1'b0;
    repeat (rate) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (rate) @(negedge clk);
    end
    rxd = stop;
    repeat (rate) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * rate) @(negedge clk);
  endtask

  task automatic count_lows(input int n,
                            output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic [7:0] txb;
    logic [31:0] d;
    int lows;
    bus.cs = 1'b0;
    bus.we = 1'b0;
    bus.address = '0;
    bus.write_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_rdata", bus.read_data, 32'd0);
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_txd", {31'b0, txd}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    rd_chk("rate_rst", 8'h10, 32'd217);
    rd_chk("rxst_rst", 8'h20, 32'd0);
    rd_chk("rxcnt_rst", 8'h22, 32'd0);
    rd_chk("txst_rst", 8'h40, 32'd1);
    @(negedge clk);
    check("ready_drop", {31'b0, bus.ready}, 32'd0);
    check("rdata_idle", bus.read_data, 32'd0);

    // unmapped, bit-rate clamp
    rd_chk("unmapped", 8'h33, 32'd0);
    bus_wr(8'h33, 32'hFFFF_FFFF);
    rd_chk("unmapped_w", 8'h33, 32'd0);
    bus_wr(8'h10, 32'd1);
    rd_chk("rate_clamp", 8'h10, 32'd2);
    bus_wr(8'h10, 32'd4);
    rd_chk("rate_4", 8'h10, 32'd4);

    // RX single byte
    send_frame(8'hA5, 1'b1, 4);
    rd_chk("rx_st1", 8'h20, 32'd1);
    rd_chk("rx_cnt1", 8'h22, 32'd1);
    rd_chk("rx_data", 8'h21, 32'hA5);
    rd_chk("rx_st0", 8'h20, 32'd0);
    rd_chk("rx_cnt0", 8'h22, 32'd0);
    rd_chk("rx_empty", 8'h21, 32'd0);

    // TX waveform, sampled mid-bit
    txb = 8'h3C;
    bus_wr(8'h41, 32'h3C);
    repeat (2) @(negedge clk);
    check("tx_start", {31'b0, txd}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (4) @(negedge clk);
      check("tx_bit", {31'b0, txd}, {31'b0, txb[k]});
    end
    repeat (4) @(negedge clk);
    check("tx_stop", {31'b0, txd}, 32'd1);
    repeat (4) @(negedge clk);
    rd_chk("tx_idle", 8'h40, 32'd1);

    // TX write while busy is ignored
    bus_wr(8'h41, 32'h3C);
    bus_wr(8'h41, 32'h81);
    rd_chk("tx_busy", 8'h40, 32'd0);
    repeat (30) @(negedge clk);
    rd_chk("tx_busy2", 8'h40, 32'd0);
    repeat (4) @(negedge clk);
    rd_chk("tx_done", 8'h40, 32'd1);
    count_lows(50, lows);
    check("tx_no_2nd", lows, 32'd0);

    // overrun: 17 frames, no reads
    for (int i = 0; i < 17; i++)
      send_frame(8'h40 + 8'(i), 1'b1, 4);
    rd_chk("ovr_cnt", 8'h22, 32'd16);
    rd_chk("ovr_st", 8'h20, 32'd3);
    rd_chk("ovr_st2", 8'h20, 32'd1);
    rd_chk("ovr_head", 8'h21, 32'h40);
    for (int i = 1; i < 16; i++)
      rd_chk("ovr_drain", 8'h21, 32'h40 + i);
    rd_chk("ovr_cnt0", 8'h22, 32'd0);

    // framing error
    send_frame(8'h77, 1'b0, 4);
    rd_chk("fe_cnt", 8'h22, 32'd0);
    rd_chk("fe_st", 8'h20, 32'd4);
    rd_chk("fe_clr", 8'h20, 32'd0);
    send_frame(8'h12, 1'b1, 4);
    rd_chk("fe_recover", 8'h21, 32'h12);

`ifdef UART_LOOPBACK_EN
    bus_wr(8'h50, 32'd1);
    rd_chk("lb_reg", 8'h50, 32'd1);
    bus_wr(8'h41, 32'h5A);
    count_lows(50, lows);
    check("lb_txd_high", lows, 32'd0);
    rd_chk("lb_data", 8'h21, 32'h5A);
    bus_wr(8'h50, 32'd0);
`else
    bus_wr(8'h50, 32'd1);
    rd_chk("lb_unmapped", 8'h50, 32'd0);
`endif

    // reset mid-frame
    bus_wr(8'h41, 32'h00);
    repeat (3) @(negedge clk);
    check("mid_low", {31'b0, txd}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_txd", {31'b0, txd}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("mid_rate", 8'h10, 32'd217);
    rd_chk("mid_txst", 8'h40, 32'd1);
    rd_chk("mid_cnt", 8'h22, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
